booth_mult: RTL and testbench

BOOTH_MULT -- requirements
Module: booth_mult

---
 rtl/booth_pkg.sv | 36 +++
 rtl/booth_recoder.sv | 44 ++++
 rtl/booth_mult.sv | 124 ++++++++++++
 tb/tb_booth_mult.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// ============================================================================
// Module   : booth_pkg
// Brief    : Shared state type and sizing constants for the Booth multiplier.
//            Macro BOOTH_RADIX4_EN selects radix-4 modified Booth recoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 32;

`ifdef BOOTH_RADIX4_EN
    localparam int BITS_PER_STEP = 2;
    localparam int RECODE_BITS   = 3;
`else
    localparam int BITS_PER_STEP = 1;
    localparam int RECODE_BITS   = 2;
`endif

    localparam int STEPS = WIDTH_DEFAULT / BITS_PER_STEP;

    // Radix-4 retires two multiplier bits per step, so WIDTH must be even there.
    function automatic int booth_steps(input int width);
        return width / BITS_PER_STEP;
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_recoder.sv
// ============================================================================
// Module   : booth_recoder
// Brief    : Combinational Booth recoder: maps recode bits and multiplicand M
//            to the signed addend (0, +-M, and +-2M when BOOTH_RADIX4_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_recoder
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [RECODE_BITS-1:0] recode_i,
    input  logic [WIDTH-1:0]       m_i,
    output logic [WIDTH+1:0]       addend_o
);

    logic [WIDTH+1:0] m_ext;

    assign m_ext = {{2{m_i[WIDTH-1]}}, m_i};

    always_comb begin
        addend_o = '0;
`ifdef BOOTH_RADIX4_EN
        case (recode_i)
            3'b001, 3'b010: addend_o = m_ext;
            3'b011:         addend_o = m_ext << 1;
            3'b100:         addend_o = -(m_ext << 1);
            3'b101, 3'b110: addend_o = -m_ext;
            default:        addend_o = '0;
        endcase
`else
        case (recode_i)
            2'b01:   addend_o = m_ext;
            2'b10:   addend_o = -m_ext;
            default: addend_o = '0;
        endcase
`endif
    end

endmodule

`default_nettype wire

// File: rtl/booth_mult.sv
// ============================================================================
// Module   : booth_mult
// Brief    : Iterative signed Booth multiplier (IDLE/BUSY/DONE), registered
//            product and one-cycle is_done pulse. Radix-4 if BOOTH_RADIX4_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     mult_op1,
    input  logic [WIDTH-1:0]     mult_op2,
    input  logic                 start,
    output logic                 is_done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int AW     = WIDTH + 2;
    localparam int NSTEPS = booth_steps(WIDTH);
    localparam int CW     = $clog2(NSTEPS + 1);
    localparam int SW     = AW + WIDTH + 1;

    state_t               state_q, state_d;
    logic [AW-1:0]        a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic                 qm1_q, qm1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 done_q, done_d;

    logic [RECODE_BITS-1:0] recode;
    logic [AW-1:0]          addend;
    logic [AW-1:0]          sum;
    logic [SW-1:0]          shifted;

    assign recode = {q_q[RECODE_BITS-2:0], qm1_q};

    booth_recoder #(
        .WIDTH (WIDTH)
    ) u_recoder (
        .recode_i (recode),
        .m_i      (m_q),
        .addend_o (addend)
    );

    // One Booth step: accumulate, then arithmetic shift of {A,Q,Q-1}.
    assign sum     = a_q + addend;
    assign shifted = $signed({sum, q_q, qm1_q}) >>> BITS_PER_STEP;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        q_d      = q_q;
        m_d      = m_q;
        qm1_d    = qm1_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = mult_op2;
                    m_d     = mult_op1;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_d   = shifted[SW-1:WIDTH+1];
                q_d   = shifted[WIDTH:1];
                qm1_d = shifted[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NSTEPS - 1)) begin
                    // Product is the low WIDTH bits of A above the full Q.
                    result_d = shifted[2*WIDTH:1];
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            q_q      <= '0;
            m_q      <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            q_q      <= q_d;
            m_q      <= m_d;
            qm1_q    <= qm1_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign is_done = done_q;
    assign result  = result_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_mult.sv
// ============================================================================
// Module   : tb_booth_mult
// Brief    : Self-checking bench for booth_mult (directed vectors plus a
//            random sweep against a 64-bit signed model). Honours BOOTH_RADIX4_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_mult;

`ifdef BOOTH_RADIX4_EN
    localparam int STEPS = 16;
`else
    localparam int STEPS = 32;
`endif
    localparam int PERIOD = STEPS + 2;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op1   = '0;
    logic [31:0] op2   = '0;
    logic        is_done;
    logic [63:0] result;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;
    bit scramble = 1'b0;

    always #5 clk = ~clk;

    booth_mult #(
        .WIDTH (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mult_op1 (op1),
        .mult_op2 (op2),
        .start    (start),
        .is_done  (is_done),
        .result   (result)
    );

    always @(negedge clk) if (is_done === 1'b1) pulses++;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts rising edges until is_done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (scramble) begin
                op1   = $urandom;
                op2   = $urandom;
                start = 1'($urandom_range(0, 1));
            end
        end while (is_done !== 1'b1 && n < 200);
        if (scramble) start = 1'b0;
    endtask

    // Called #1 after a rising edge with the DUT idle; leaves it idle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string tag);
        int n;
        op1 = a; op2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        check_val({tag, "_lat"}, 64'(n), 64'(STEPS));
        check_val(tag, result, exp);
        @(posedge clk); #1;
        check_val({tag, "_pulse"}, {63'b0, is_done}, 64'b0);
    endtask

    initial begin
        int n;
        int p0;
        longint sa, sb;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_result", result, 64'h0);
        check_val("rst_done", {63'b0, is_done}, 64'b0);
        rst = 1'b1;

        // Back-to-back with start held high
        op1 = 32'h0000_00FF; op2 = 32'h8000_00FF; start = 1'b1;
        wait_done(n);
        check_val("b2b_lat1", 64'(n), 64'(STEPS + 1));
        check_val("b2b_res1", result, 64'hFFFF_FF80_8000_FE01);
        wait_done(n);
        start = 1'b0;
        check_val("b2b_period", 64'(n), 64'(PERIOD));
        check_val("b2b_res2", result, 64'hFFFF_FF80_8000_FE01);
        @(posedge clk); #1;
        check_val("b2b_pulse", {63'b0, is_done}, 64'b0);

        do_op(32'd3,         32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, "neg_small");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "m1_m1");
        do_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_min");
        do_op(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, "max_min");
        do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, "max_max");
        do_op(32'd1,         32'h8000_0000, 64'hFFFF_FFFF_8000_0000, "one_min");
        do_op(32'd0,         32'h8000_0000, 64'h0,                   "zero");

        // Operands and start wiggle while busy
        scramble = 1'b1;
        do_op(32'd5, 32'd7, 64'd35, "opchg");
        scramble = 1'b0;

        // Reset in the middle of an operation
        op1 = 32'h0001_2345; op2 = 32'h11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("abort_result", result, 64'h0);
        check_val("abort_done", {63'b0, is_done}, 64'b0);
        p0 = pulses;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_val("abort_nopulse", 64'(pulses - p0), 64'd0);
        do_op(32'h0001_2345, 32'h11, 64'h0000_0000_0013_5795, "after_abort");

        // Random signed pairs against a 64-bit model
        p0 = pulses;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            sa = longint'($signed(ra));
            sb = longint'($signed(rb));
            do_op(ra, rb, 64'(sa * sb), "rand");
        end
        check_val("rand_pulses", 64'(pulses - p0), 64'd1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
